// File: rtl/image_window_gen.sv
// image_window_gen
//   Collects one 3x3 image in raster order and then presents its four
//   overlapping 2x2 windows one at a time over a valid/ready handshake.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous reset, active low
//   pix_in      incoming pixel (raster order)
//   pix_valid   pix_in is valid
//   pix_ready   block can take a pixel this cycle (LOAD)
//   win_pixels  {bottom-right, bottom-left, top-right, top-left}, 0 when idle
//   win_valid   window outputs are valid (EMIT)
//   win_ready   downstream takes the window
//   win_idx     window position 0..3 = (r0,c0),(r0,c1),(r1,c0),(r1,c1)
//   win_last    high with the final window of the frame
//   frame_done  one-cycle pulse after the final window is taken
//   win_sum     (only with IMAGE_WINDOW_GEN_SUM_EN) unsigned sum of the
//               four window pixels, 0 when idle
//
// Build option
//   IMAGE_WINDOW_GEN_SUM_EN  adds the win_sum output.
//
// state | meaning
// ------+---------------------------------------------
// LOAD  | accepting pixels until all 9 are buffered
// EMIT  | presenting windows 0..3, buffer frozen

module image_window_gen #(
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [4*PIX_W-1:0] win_pixels,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [1:0]         win_idx,
  output logic               win_last,
  output logic               frame_done
`ifdef IMAGE_WINDOW_GEN_SUM_EN
  ,
  output logic [PIX_W+1:0]   win_sum
`endif
);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       count;
  logic [1:0]       idx;
  logic [PIX_W-1:0] pix_buf [9];
  logic             pix_xfer;
  logic             win_xfer;
  logic [3:0]       base;
  logic [PIX_W-1:0] tl, tr, bl, br;

  assign pix_xfer = pix_valid && (state == LOAD);
  assign win_xfer = win_ready && (state == EMIT);

  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    win_valid = 1'b0;
    case (state)
      LOAD: begin
        pix_ready = 1'b1;
        if (pix_xfer && count == 4'd8) state_nxt = EMIT;
      end
      EMIT: begin
        win_valid = 1'b1;
        if (win_xfer && idx == 2'd3) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) pix_buf[i] <= '0;
    end else begin
      frame_done <= win_xfer && (idx == 2'd3);
      if (pix_xfer) begin
        pix_buf[count] <= pix_in;
        count          <= (count == 4'd8) ? 4'd0 : count + 4'd1;
      end
      // idx wraps 3 -> 0, so the next frame starts at window 0
      if (win_xfer) idx <= idx + 2'd1;
    end
  end

  // Top-left buffer index of the current window: row*3 + col
  assign base = (idx[1] ? 4'd3 : 4'd0) + {3'b000, idx[0]};
  assign tl   = pix_buf[base];
  assign tr   = pix_buf[base + 4'd1];
  assign bl   = pix_buf[base + 4'd3];
  assign br   = pix_buf[base + 4'd4];

  assign win_pixels = win_valid ? {br, bl, tr, tl} : '0;
  assign win_idx    = idx;
  assign win_last   = win_valid && (idx == 2'd3);

`ifdef IMAGE_WINDOW_GEN_SUM_EN
  assign win_sum = win_valid ? ({2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br}) : '0;
`endif

endmodule

// File: tb/tb_image_window_gen.sv
module tb_image_window_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] win_pixels;
  logic        win_valid;
  logic        win_ready;
  logic [1:0]  win_idx;
  logic        win_last;
  logic        frame_done;
`ifdef IMAGE_WINDOW_GEN_SUM_EN
  logic [9:0]  win_sum;
`endif

  always #5 clk = ~clk;

  image_window_gen #(.PIX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_pixels (win_pixels),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_idx    (win_idx),
    .win_last   (win_last),
    .frame_done (frame_done)
`ifdef IMAGE_WINDOW_GEN_SUM_EN
    ,
    .win_sum    (win_sum)
`endif
  );

  typedef struct {
    logic [31:0] pix;
    logic [1:0]  idx;
    logic        last;
    logic [9:0]  sum;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   frames_seen = 0;
  logic fd_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push4(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3,
                       input logic [9:0] s0, input logic [9:0] s1,
                       input logic [9:0] s2, input logic [9:0] s3);
    q.push_back('{w0, 2'd0, 1'b0, s0});
    q.push_back('{w1, 2'd1, 1'b0, s1});
    q.push_back('{w2, 2'd2, 1'b0, s2});
    q.push_back('{w3, 2'd3, 1'b1, s3});
  endtask

  task automatic push_1to9();
    push4(32'h05040201, 32'h06050302, 32'h08070504, 32'h09080605,
          10'd12, 10'd16, 10'd24, 10'd28);
  endtask

  // Monitor: compares every accepted window against the scoreboard and
  // checks the frame_done pulse lands exactly one cycle after the last one.
  always @(negedge clk) begin
    if (rst) begin
      chk("frame_done", frame_done, fd_pending);
      if (frame_done) begin
        frames_seen++;
        chk("pix_ready_in_done_cycle", pix_ready, 1);
      end
      fd_pending = 1'b0;
      if (!win_valid) begin
        chk("win_pixels_idle", win_pixels, 0);
      end else if (win_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_window: got %h idx %0d want none", win_pixels, win_idx);
        end else begin
          e = q.pop_front();
          chk("win_pixels", win_pixels, e.pix);
          chk("win_idx", win_idx, e.idx);
          chk("win_last", win_last, e.last);
`ifdef IMAGE_WINDOW_GEN_SUM_EN
          chk("win_sum", win_sum, e.sum);
`endif
          fd_pending = e.last;
        end
      end
    end else begin
      fd_pending = 1'b0;
    end
  end

  task automatic send(input logic [7:0] p, input bit fd_chk);
    pix_in    = p;
    pix_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pix_ready) break;
    end
    if (!pix_ready) begin
      total++;
      bad++;
      $display("FAIL pixel_accept_timeout: got pix_ready 0 want 1");
    end
    if (fd_chk) chk("first_pixel_in_done_cycle", frame_done, 1);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d windows pending want 0", q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_win_pixels", win_pixels, 0);
    chk("rst_win_idx", win_idx, 0);
`ifdef IMAGE_WINDOW_GEN_SUM_EN
    chk("rst_win_sum", win_sum, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_in    = 8'h00;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // basic frame, downstream always ready
    push_1to9();
    for (int p = 1; p <= 9; p++) send(8'(p), 1'b0);
    wait_drain();

    // stall three cycles on window 1
    push_1to9();
    for (int p = 1; p <= 9; p++) send(8'(p), 1'b0);
    @(posedge clk);
    #1;
    win_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", win_valid, 1);
      chk("stall_pixels", win_pixels, 32'h06050302);
      chk("stall_idx", win_idx, 1);
      chk("stall_last", win_last, 0);
      @(posedge clk);
      #1;
    end
    win_ready = 1'b1;
    wait_drain();

    // bubbles between pixels, junk pixels offered during EMIT
    push_1to9();
    for (int p = 1; p <= 9; p++) begin
      send(8'(p), 1'b0);
      if (p != 9) begin
        @(posedge clk);
        #1;
      end
    end
    pix_in    = 8'hFF;
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_in    = 8'h00;
    wait_drain();

    // two frames back to back
    push_1to9();
    push4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
          10'd1020, 10'd1020, 10'd1020, 10'd1020);
    for (int p = 1; p <= 9; p++) send(8'(p), 1'b0);
    for (int i = 0; i < 9; i++) send(8'hFF, i == 0);
    wait_drain();

    // reset after a partial frame, with a pixel offered on the reset edge
    for (int p = 1; p <= 5; p++) send(8'(p), 1'b0);
    rst       = 1'b0;
    pix_in    = 8'h77;
    pix_valid = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #1;
    push4(32'h0E0D0B0A, 32'h0F0E0C0B, 32'h11100E0D, 32'h12110F0E,
          10'd48, 10'd52, 10'd60, 10'd64);
    for (int p = 10; p <= 18; p++) send(8'(p), 1'b0);
    wait_drain();

    chk("frames_completed", frames_seen, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_window_gen.md
IMAGE_WINDOW_GEN -- requirements
Module: image_window_gen

Interface
REQ-001 SHALL have parameter: PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 SHALL have port: pix_in  input  PIX_W  incoming image pixel, raster order (row 0 col 0 first).
REQ-005 SHALL have port: pix_valid  input  1  pix_in valid.
REQ-006 SHALL have port: pix_ready  output  1  block accepts a pixel this cycle.
REQ-007 SHALL have port: win_pixels  output  4*PIX_W  2x2 window: [PIX_W-1:0]=top-left, next=top-right, next=bottom-left, top slice=bottom-right.
REQ-008 SHALL have port: win_valid  output  1  win_pixels/win_idx valid.
REQ-009 SHALL have port: win_ready  input  1  downstream classifier accepts window.
REQ-010 SHALL have port: win_idx  output  2  window position: 0=(r0,c0), 1=(r0,c1), 2=(r1,c0), 3=(r1,c1).
REQ-011 SHALL have port: win_last  output  1  high with win_valid when win_idx=3.
REQ-012 SHALL have port: frame_done  output  1  one-cycle pulse after window 3 accepted.

Function
REQ-013 SHALL buffer one 3x3 image (9 pixels) and emit its four overlapping 2x2 windows, in win_idx order 0..3.
REQ-014 SHALL implement states LOAD (pix_ready=1, win_valid=0) and EMIT (pix_ready=0, win_valid=1).
REQ-015 Pixel transfer SHALL occur on a cycle with pix_valid=1 and pix_ready=1; the pixel is stored at index count (row*3+col), and count increments.
REQ-016 pix_valid=0 in LOAD SHALL leave count and buffer unchanged (bubbles allowed anywhere).
REQ-017 On the 9th transfer SHALL move to EMIT; win_valid=1 with win_idx=0 on the next cycle (latency 1 cycle from last pixel).
REQ-018 Window transfer SHALL occur on a cycle with win_valid=1 and win_ready=1; win_idx increments on each transfer.
REQ-019 While win_valid=1 and win_ready=0, win_pixels, win_idx and win_last SHALL hold stable.
REQ-020 Back-to-back acceptance (win_ready held 1) SHALL emit one window per cycle, 4 cycles per frame.
REQ-021 On transfer of window 3, SHALL return to LOAD with count=0; frame_done=1 for exactly the next cycle, with pix_ready=1 in that same cycle.
REQ-022 pix_valid asserted during EMIT SHALL be ignored (no capture, no count change).
REQ-023 win_pixels SHALL be 0 whenever win_valid=0.
REQ-024 The buffer is overwritten by the next frame; no pixel data SHALL leak between frames (every window uses only the current frame's 9 pixels).

Reset
REQ-025 rst=0 at a rising edge SHALL force: state LOAD, count=0, win_idx=0, buffer all zero, pix_ready=1, win_valid=0, win_last=0, frame_done=0, win_pixels=0.
REQ-026 Reset mid-LOAD or mid-EMIT SHALL discard the partial frame; no window or frame_done is emitted for it.
REQ-027 Reset SHALL take priority over simultaneous pixel or window transfers.

Configuration
REQ-028 Macro IMAGE_WINDOW_GEN_SUM_EN defined: SHALL add output win_sum (PIX_W+2 bits) = unsigned sum of the 4 window pixels, valid and stable with win_valid, 0 otherwise and at reset.
REQ-029 Macro undefined: win_sum port SHALL NOT exist; all other behaviour identical.

Verification
REQ-030 Reset then pixels 1..9 streamed, win_ready=1 -> windows 0x05040201, 0x06050302, 0x08070504, 0x09080605 with idx 0..3, win_last only on last, frame_done pulses once.
REQ-031 Same frame, win_ready=0 for 3 cycles at window 1 -> win_pixels=0x06050302, win_idx=1 held stable for 3 cycles; sequence otherwise unchanged.
REQ-032 pix_valid toggling 1/0 every cycle across pixels 1..9 -> same 4 windows; pix_in driven 0xFF during EMIT ignored.
REQ-033 rst=0 after 5 pixels, then frame 10..18 -> first window 0x0E0D0B0A; no window from partial frame.
REQ-034 Two frames back-to-back (1..9 then 0xFF x9) -> second frame windows all 0xFFFFFFFF; pixel 1 of frame 2 accepted in the frame_done cycle.
REQ-035 With IMAGE_WINDOW_GEN_SUM_EN, frame 1..9 -> win_sum 12, 16, 24, 28; all 0xFF frame -> win_sum 1020 (0x3FC).
